// File: rtl/lift_call_queue_pkg.sv
// -----------------------------------------------------------------------------
// lift_pkg
// Definitions shared between the call queue and the lift controller: the floor
// code width, the "no floor" code and the sweep direction / FSM state encoding.
// -----------------------------------------------------------------------------
package lift_pkg;

    localparam int FLOOR_W = 3;

    localparam logic [FLOOR_W-1:0] NONE_FLOOR = '0;

    // Sweep direction; the queue FSM uses the same codes as its state.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        UP   = 2'b01,
        DOWN = 2'b10
    } dir_e;

endpackage

// File: rtl/lift_call_queue_if.sv
// -----------------------------------------------------------------------------
// lift_call_queue_if
// Valid/ready target handshake from the call queue to the lift controller.
//   tgt_valid : a target floor is offered
//   tgt_floor : offered floor, 1..NFLOORS
//   tgt_ready : downstream accepts the offer (transfer when both are high)
// master = call queue, slave = lift controller.
// -----------------------------------------------------------------------------
interface lift_call_queue_if;
    import lift_pkg::*;

    logic               tgt_valid;
    logic [FLOOR_W-1:0] tgt_floor;
    logic               tgt_ready;

    modport master (
        output tgt_valid,
        output tgt_floor,
        input  tgt_ready
    );

    modport slave (
        input  tgt_valid,
        input  tgt_floor,
        output tgt_ready
    );

endinterface

// File: rtl/lift_call_queue_pick_floor.sv
// -----------------------------------------------------------------------------
// lift_pick_floor
// Combinational search of the pending-call map relative to the cab position.
//   pending     : pending-call map, bit i-1 = floor i
//   cur_floor   : current cab floor, already clamped to 1..NFLOORS
//   above_floor : lowest pending floor strictly above cur_floor (0 if none)
//   above_found : above_floor is valid
//   below_floor : highest pending floor strictly below cur_floor (0 if none)
//   below_found : below_floor is valid
// -----------------------------------------------------------------------------
module lift_pick_floor
    import lift_pkg::*;
#(
    parameter int NFLOORS = 7
) (
    input  logic [NFLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0] cur_floor,
    output logic [FLOOR_W-1:0] above_floor,
    output logic               above_found,
    output logic [FLOOR_W-1:0] below_floor,
    output logic               below_found
);

    always_comb begin
        above_floor = NONE_FLOOR;
        above_found = 1'b0;
        below_floor = NONE_FLOOR;
        below_found = 1'b0;
        // Scan top-down so the last hit is the lowest floor above the cab.
        for (int i = NFLOORS; i >= 1; i--) begin
            if (pending[i-1] && (FLOOR_W'(i) > cur_floor)) begin
                above_floor = FLOOR_W'(i);
                above_found = 1'b1;
            end
        end
        // Scan bottom-up so the last hit is the highest floor below the cab.
        for (int i = 1; i <= NFLOORS; i++) begin
            if (pending[i-1] && (FLOOR_W'(i) < cur_floor)) begin
                below_floor = FLOOR_W'(i);
                below_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lift_call_queue.sv
// -----------------------------------------------------------------------------
// lift_call_queue
// Merges hall and cab calls into one pending bit per floor and offers the next
// target floor to the lift controller following an up/down sweep.
//   clk, rst_n     : clock, asynchronous active-low reset
//   hall_call      : per-floor hall button pulses (bit i-1 = floor i)
//   cab_call_valid : cab button strobe
//   cab_call_floor : floor requested from the cab (0 / out of range ignored)
//   elev_f_i       : current cab floor (0 / out of range treated as floor 1)
//   busy_i         : lift controller busy, no new offer while high
//   tgt            : target handshake (master side)
//   pending_o      : pending-call map
//   dir_o          : sweep direction / FSM state (00 idle, 01 up, 10 down)
// -----------------------------------------------------------------------------
module lift_call_queue
    import lift_pkg::*;
#(
    parameter int NFLOORS = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NFLOORS-1:0] hall_call,
    input  logic               cab_call_valid,
    input  logic [FLOOR_W-1:0] cab_call_floor,
    input  logic [FLOOR_W-1:0] elev_f_i,
    input  logic               busy_i,
    lift_call_queue_if.master  tgt,
    output logic [NFLOORS-1:0] pending_o,
    output logic [1:0]         dir_o
);

    function automatic logic [FLOOR_W-1:0] clamp_floor(input logic [FLOOR_W-1:0] f);
        if ((f == NONE_FLOOR) || (int'(f) > NFLOORS)) return FLOOR_W'(1);
        return f;
    endfunction

    // One-hot floor mask; floor 0 and out-of-range codes give an empty mask.
    function automatic logic [NFLOORS-1:0] floor_mask(input logic [FLOOR_W-1:0] f);
        logic [NFLOORS-1:0] m;
        m = '0;
        for (int i = 1; i <= NFLOORS; i++) begin
            if (f == FLOOR_W'(i)) m[i-1] = 1'b1;
        end
        return m;
    endfunction

    logic [NFLOORS-1:0] pending_p1;
    dir_e               state_p1;
    logic               tgt_vld_p1;
    logic [FLOOR_W-1:0] tgt_floor_p1;

    logic [FLOOR_W-1:0] cur_floor;
    logic [FLOOR_W-1:0] above_floor, below_floor;
    logic               above_found, below_found;
    logic [FLOOR_W-1:0] dist_up, dist_dn;
    logic [NFLOORS-1:0] call_set, call_clr, pending_nxt;
    logic               xfer, can_offer;
    dir_e               state_nxt;
    logic               pick_vld;
    logic [FLOOR_W-1:0] pick_floor;

    lift_pick_floor #(.NFLOORS(NFLOORS)) u_pick (
        .pending     (pending_p1),
        .cur_floor   (cur_floor),
        .above_floor (above_floor),
        .above_found (above_found),
        .below_floor (below_floor),
        .below_found (below_found)
    );

    always_comb begin
        cur_floor = clamp_floor(elev_f_i);
        xfer      = tgt_vld_p1 && tgt.tgt_ready;
        // Offers (and direction decisions) only happen with the lift free and
        // nothing outstanding, so an outstanding offer is never retargeted.
        can_offer = !tgt_vld_p1 && !busy_i;

        call_set = hall_call | (cab_call_valid ? floor_mask(cab_call_floor) : '0);
        call_clr = '0;
        if (xfer)      call_clr = call_clr | floor_mask(tgt_floor_p1);
        if (can_offer) call_clr = call_clr | floor_mask(cur_floor);
        // Clear has priority over a same-cycle call to the same floor.
        pending_nxt = (pending_p1 | call_set) & ~call_clr;

        dist_up = above_floor - cur_floor;
        dist_dn = cur_floor - below_floor;

        state_nxt  = state_p1;
        pick_vld   = 1'b0;
        pick_floor = NONE_FLOOR;
        case (state_p1)
            IDLE: begin
                // Nearest pending floor; equal distance resolves upward.
                if (above_found && (!below_found || (dist_up <= dist_dn))) begin
                    state_nxt = UP;   pick_vld = 1'b1; pick_floor = above_floor;
                end else if (below_found) begin
                    state_nxt = DOWN; pick_vld = 1'b1; pick_floor = below_floor;
                end
            end
            UP: begin
                if (above_found) begin
                    pick_vld = 1'b1; pick_floor = above_floor;
                end else if (below_found) begin
                    state_nxt = DOWN; pick_vld = 1'b1; pick_floor = below_floor;
                end else begin
                    state_nxt = IDLE;
                end
            end
            DOWN: begin
                if (below_found) begin
                    pick_vld = 1'b1; pick_floor = below_floor;
                end else if (above_found) begin
                    state_nxt = UP; pick_vld = 1'b1; pick_floor = above_floor;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Registered stage: pending map, sweep state and target offer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_p1   <= '0;
            state_p1     <= IDLE;
            tgt_vld_p1   <= 1'b0;
            tgt_floor_p1 <= NONE_FLOOR;
        end else begin
            pending_p1 <= pending_nxt;
            if (can_offer) begin
                state_p1   <= state_nxt;
                tgt_vld_p1 <= pick_vld;
                if (pick_vld) tgt_floor_p1 <= pick_floor;
            end else if (xfer) begin
                tgt_vld_p1 <= 1'b0;
            end
        end
    end

    assign tgt.tgt_valid = tgt_vld_p1;
    assign tgt.tgt_floor = tgt_floor_p1;
    assign pending_o     = pending_p1;
    assign dir_o         = state_p1;

endmodule

// File: tb/tb_lift_call_queue.sv
// -----------------------------------------------------------------------------
// tb_lift_call_queue
// Self-checking bench for lift_call_queue: directed scenarios followed by
// randomized traffic, every cycle compared against a behavioural model that
// keeps the pending calls as a per-floor array and searches outward by distance.
// -----------------------------------------------------------------------------
module tb_lift_call_queue;
    import lift_pkg::*;

    localparam int NF = 7;

    logic          clk;
    logic          rst_n;
    logic [NF-1:0] hall_call;
    logic          cab_call_valid;
    logic [2:0]    cab_call_floor;
    logic [2:0]    elev_f_i;
    logic          busy_i;
    logic [NF-1:0] pending_o;
    logic [1:0]    dir_o;

    lift_call_queue_if tgt_if ();

    lift_call_queue #(.NFLOORS(NF)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .hall_call      (hall_call),
        .cab_call_valid (cab_call_valid),
        .cab_call_floor (cab_call_floor),
        .elev_f_i       (elev_f_i),
        .busy_i         (busy_i),
        .tgt            (tgt_if),
        .pending_o      (pending_o),
        .dir_o          (dir_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference model state
    bit m_pend [1:NF];
    int m_dir;      // 0 idle, 1 up, 2 down
    bit m_vld;
    int m_tfl;

    function automatic logic [NF-1:0] m_map();
        logic [NF-1:0] m;
        for (int f = 1; f <= NF; f++) m[f-1] = m_pend[f];
        return m;
    endfunction

    task automatic model_reset();
        for (int f = 1; f <= NF; f++) m_pend[f] = 1'b0;
        m_dir = 0;
        m_vld = 1'b0;
        m_tfl = 0;
    endtask

    // Next state of the model from its current state and the present inputs.
    task automatic model_step();
        bit np [1:NF];
        int cur, tgt, up_t, dn_t, new_dir;
        bit xfer, can;
        cur  = (elev_f_i == 0 || elev_f_i > NF) ? 1 : int'(elev_f_i);
        xfer = m_vld && tgt_if.tgt_ready;
        can  = !m_vld && !busy_i;
        for (int f = 1; f <= NF; f++)
            np[f] = m_pend[f] || hall_call[f-1] || (cab_call_valid && cab_call_floor == f);
        if (xfer) np[m_tfl] = 1'b0;
        if (can)  np[cur]   = 1'b0;
        if (can) begin
            up_t = 0; dn_t = 0; tgt = 0; new_dir = m_dir;
            for (int d = 1; d < NF; d++) begin
                if (up_t == 0 && cur + d <= NF && m_pend[cur + d]) up_t = cur + d;
                if (dn_t == 0 && cur - d >= 1  && m_pend[cur - d]) dn_t = cur - d;
            end
            if (m_dir == 0) begin
                // Walk outward one floor at a time, looking up before down.
                for (int d = 1; d < NF; d++) begin
                    if (tgt == 0) begin
                        if (cur + d <= NF && m_pend[cur + d]) begin
                            tgt = cur + d; new_dir = 1;
                        end else if (cur - d >= 1 && m_pend[cur - d]) begin
                            tgt = cur - d; new_dir = 2;
                        end
                    end
                end
            end else if (m_dir == 1) begin
                if (up_t != 0)      begin tgt = up_t; new_dir = 1; end
                else if (dn_t != 0) begin tgt = dn_t; new_dir = 2; end
                else                new_dir = 0;
            end else begin
                if (dn_t != 0)      begin tgt = dn_t; new_dir = 2; end
                else if (up_t != 0) begin tgt = up_t; new_dir = 1; end
                else                new_dir = 0;
            end
            m_dir = new_dir;
            m_vld = (tgt != 0);
            if (tgt != 0) m_tfl = tgt;
        end else if (xfer) begin
            m_vld = 1'b0;
        end
        for (int f = 1; f <= NF; f++) m_pend[f] = np[f];
    endtask

    task automatic compare_all(input string tag);
        chk({tag, "_pending"}, pending_o, m_map());
        chk({tag, "_dir"}, dir_o, m_dir);
        chk({tag, "_vld"}, tgt_if.tgt_valid, m_vld);
        if (m_vld) chk({tag, "_floor"}, tgt_if.tgt_floor, m_tfl);
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_pending"}, pending_o, 0);
        chk({tag, "_dir"}, dir_o, 0);
        chk({tag, "_vld"}, tgt_if.tgt_valid, 0);
        chk({tag, "_floor"}, tgt_if.tgt_floor, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        hall_call = '0; cab_call_valid = 1'b0; cab_call_floor = 3'd0;
        elev_f_i = 3'd1; busy_i = 1'b0; tgt_if.tgt_ready = 1'b0;
        model_reset();
        #12;
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single hall call to floor 3 from floor 1
        tgt_if.tgt_ready = 1'b1;
        hall_call = 7'b0000100;
        tick("r035_set");
        chk("r035_bit2", pending_o, 7'b0000100);
        hall_call = '0;
        tick("r035_offer");
        chk("r035_tgt", tgt_if.tgt_floor, 3);
        chk("r035_dirup", dir_o, 1);
        tick("r035_xfer");
        chk("r035_clear", pending_o, 0);
        tick("r035_idle");

        // Held offer is not retargeted by a nearer call
        tgt_if.tgt_ready = 1'b0;
        hall_call = 7'b0010000;
        tick("r036_set");
        hall_call = '0;
        tick("r036_offer");
        cab_call_valid = 1'b1; cab_call_floor = 3'd2;
        tick("r036_cab");
        cab_call_valid = 1'b0;
        tick("r036_hold");
        chk("r036_hold5", tgt_if.tgt_floor, 5);
        tgt_if.tgt_ready = 1'b1;
        tick("r036_xfer");
        tick("r036_next");
        chk("r036_next2", tgt_if.tgt_floor, 2);
        tick("r036_xfer2");
        tick("r036_idle");

        // Sweep up to 6, then reverse down to 2
        tgt_if.tgt_ready = 1'b0; busy_i = 1'b1; elev_f_i = 3'd4;
        hall_call = 7'b0100010;
        tick("r037_set");
        hall_call = '0; busy_i = 1'b0;
        tick("r037_offer");
        chk("r037_up6", tgt_if.tgt_floor, 6);
        tgt_if.tgt_ready = 1'b1; busy_i = 1'b1;
        tick("r037_xfer");
        elev_f_i = 3'd6; busy_i = 1'b0;
        tick("r037_rev");
        chk("r037_dirdn", dir_o, 2);
        chk("r037_dn2", tgt_if.tgt_floor, 2);
        tick("r037_xfer2");
        tick("r037_idle");

        // Equal-distance tie from floor 4
        tgt_if.tgt_ready = 1'b0; elev_f_i = 3'd4;
        hall_call = 7'b0010100;
        tick("r038_set");
        hall_call = '0;
        tick("r038_offer");
        chk("r038_dir", dir_o, 1);
        chk("r038_tgt", tgt_if.tgt_floor, 5);
        tgt_if.tgt_ready = 1'b1;
        repeat (4) tick("r038_drain");

        // Ignored cab floor 0, duplicate call, own-floor call
        tgt_if.tgt_ready = 1'b0; elev_f_i = 3'd1;
        cab_call_valid = 1'b1; cab_call_floor = 3'd0;
        tick("r039_cab0");
        chk("r039_none", pending_o, 0);
        busy_i = 1'b1; cab_call_floor = 3'd7;
        tick("r039_cab7");
        tick("r039_cab7b");
        chk("r039_one", pending_o, 7'b1000000);
        cab_call_valid = 1'b0; busy_i = 1'b0;
        tick("r039_offer");
        chk("r039_tgt7", tgt_if.tgt_floor, 7);
        tgt_if.tgt_ready = 1'b1;
        tick("r039_xfer");
        tick("r039_idle");
        elev_f_i = 3'd3; hall_call = 7'b0000100;
        tick("r039_own");
        hall_call = '0;
        chk("r039_ownclr", pending_o, 0);
        tick("r039_nooffer");

        // Asynchronous reset in the middle of an offer
        tgt_if.tgt_ready = 1'b0; elev_f_i = 3'd1;
        hall_call = 7'b0010000;
        tick("r040_set");
        hall_call = '0;
        tick("r040_offer");
        chk("r040_vld", tgt_if.tgt_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("r040_async");
        model_reset();
        hall_call = 7'b1111111; cab_call_valid = 1'b1; cab_call_floor = 3'd4;
        @(posedge clk); #1;
        check_reset_outputs("r040_discard");
        hall_call = '0; cab_call_valid = 1'b0;
        rst_n = 1'b1;

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            hall_call        = ($urandom_range(0, 3) == 0) ? NF'($urandom) : '0;
            cab_call_valid   = ($urandom_range(0, 4) == 0);
            cab_call_floor   = 3'($urandom);
            elev_f_i         = 3'($urandom);
            busy_i           = ($urandom_range(0, 9) < 3);
            tgt_if.tgt_ready = $urandom_range(0, 1) == 1;
            tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lift_call_queue.md
LIFT_CALL_QUEUE -- requirements
Module: lift_call_queue

Interface
REQ-001 Parameter NFLOORS, default 7, number of floors served; floors are numbered 1..NFLOORS and floor code 0 means "none".
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 hall_call  input  NFLOORS  per-floor hall-button pulses; bit i-1 is floor i; several bits may be set in one cycle.
REQ-005 cab_call_valid  input  1  cab button strobe.
REQ-006 cab_call_floor  input  3  floor requested from the cab; sampled only while cab_call_valid=1.
REQ-007 elev_f_i  input  3  current cab floor reported by the lift controller.
REQ-008 busy_i  input  1  lift controller busy (1 = moving or serving).
REQ-009 tgt_valid  output  1  a target floor is offered downstream.
REQ-010 tgt_floor  output  3  offered target floor, 1..NFLOORS.
REQ-011 tgt_ready  input  1  downstream accepts the target; a transfer occurs when tgt_valid=1 and tgt_ready=1.
REQ-012 pending_o  output  NFLOORS  current pending-call map.
REQ-013 dir_o  output  2  sweep direction: 00 idle, 01 up, 10 down.

Function
REQ-014 The block SHALL merge hall and cab calls into one pending bit per floor and set that bit on the clock edge after the call.
REQ-015 A cab call with cab_call_floor=0 or >NFLOORS SHALL be ignored.
REQ-016 A repeated call to an already pending floor SHALL have no effect.
REQ-017 The FSM SHALL have three states: IDLE, UP and DOWN; dir_o SHALL equal the state encoding.
REQ-018 In IDLE with any pending bit set, the FSM SHALL move to UP or DOWN toward the pending floor nearest elev_f_i.
REQ-019 On an equal-distance tie in IDLE, UP SHALL win.
REQ-020 In UP, the target SHALL be the lowest pending floor above elev_f_i.
REQ-021 In UP with no pending floor above elev_f_i, the FSM SHALL move to DOWN if any pending floor is below, else to IDLE.
REQ-022 DOWN SHALL mirror UP: the target is the highest pending floor below elev_f_i, and the fallback is UP, else IDLE.
REQ-023 When the selected target is valid and no offer is outstanding, tgt_valid and tgt_floor SHALL be registered, giving 1-cycle latency from the pending bit to tgt_valid.
REQ-024 While tgt_valid=1 and tgt_ready=0, tgt_valid and tgt_floor SHALL stay stable; a newer, nearer call SHALL NOT retarget the offer.
REQ-025 On transfer, the pending bit of tgt_floor SHALL clear and tgt_valid SHALL drop in the next cycle.
REQ-026 A new offer SHALL NOT be raised while busy_i=1.
REQ-027 A pending bit for floor == elev_f_i while busy_i=0 and no offer is outstanding SHALL clear without an offer (cab already there).
REQ-028 If a call sets and the same floor clears in the same cycle, the clear SHALL win.
REQ-029 elev_f_i values of 0 or >NFLOORS SHALL be treated as floor 1 for selection.
REQ-030 All distance comparisons SHALL be unsigned 3-bit; no wrap-around between the top floor and floor 1.

Reset
REQ-031 Asserting rst_n low SHALL, asynchronously and at any time including mid-offer, force: state IDLE, pending_o all 0, tgt_valid 0, tgt_floor 0, dir_o 00.
REQ-032 Calls presented while rst_n=0 SHALL be discarded.

Structure
REQ-033 A shared package lift_pkg SHALL hold the floor width (3), the NONE_FLOOR code 0 and the direction/state encodings IDLE=00, UP=01, DOWN=10, shared with the lift controller.
REQ-034 One combinational sub-module, lift_pick_floor, SHALL return the nearest pending floor above, the nearest pending floor below and their found flags, given the pending map and the current floor.

Verification
REQ-035 Reset, then hall_call=0000100 (floor 3) with elev_f_i=1 and tgt_ready=1 -> pending_o bit2 set on the next edge; tgt_valid=1, tgt_floor=3 and dir_o=01 one cycle later; pending_o clears after the transfer.
REQ-036 Hold tgt_ready=0 with a floor-5 offer from elev_f_i=1, then issue a cab call to floor 2 -> tgt_floor stays 5 until ready; the next offer is 2 if elev_f_i is still below 2.
REQ-037 elev_f_i=4, pending floors 2 and 6, dir UP -> offer 6; after the transfer and busy_i falling with elev_f_i=6 -> dir_o=10 and offer 2.
REQ-038 elev_f_i=4, IDLE, calls to floors 3 and 5 in the same cycle -> dir_o=01 and tgt_floor=5 (tie rule).
REQ-039 Cab call to floor 0, cab call to floor 7 while it is pending, and a call at floor == elev_f_i while idle -> pending_o unchanged, a single floor-7 offer, and the own-floor bit clears with no offer.
REQ-040 Drop rst_n mid-offer (tgt_valid=1) -> all outputs reach their reset values immediately, without waiting for a clock edge.
